// File: rtl/or8way_self_test_pkg.sv
// Shared definitions for the Or8Way built-in self-test sequencer.
package or8way_self_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] NUM_VECTORS = 4'd10;
  localparam logic [3:0] LAST_INDEX  = 4'd9;
  localparam logic [3:0] FAIL_NONE   = 4'hF;

  // Test vector for an index: walking one for 0..7, all ones for 8,
  // all zeros for 9, zero for anything out of range.
  function automatic logic [7:0] vector_of(input logic [3:0] idx);
    logic [7:0] v;
    v = 8'h00;
    if (idx < 4'd8) begin
      v = 8'h01 << idx[2:0];
    end else if (idx == 4'd8) begin
      v = 8'hFF;
    end else begin
      v = 8'h00;
    end
    return v;
  endfunction

endpackage

// File: rtl/or8way_self_test_vector_rom.sv
// Combinational vector table: index -> stimulus vector and golden OR result.
module or8way_self_test_vector_rom
  import or8way_self_test_pkg::*;
(
  input  logic [3:0] index_i,
  output logic [7:0] vector_o,
  output logic       expected_o
);

  // Table lookup; the golden bit is the reduction-OR of the vector itself.
  always_comb begin
    vector_o   = vector_of(index_i);
    expected_o = |vector_o;
  end

endmodule

// File: rtl/or8way_self_test.sv
// Self-test sequencer: drives the vector table into an Or8Way, waits a
// settle time per vector and compares its output against the golden value.
module or8way_self_test
  import or8way_self_test_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] dut_in,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_index,
  output logic       led0,
  output logic       led1,
  output logic       led2,
  output logic       led3
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pass_res_q, pass_res_d;
  logic [3:0] fail_res_q, fail_res_d;

  logic [7:0] dut_in_q, dut_in_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_index_q, fail_index_d;

  logic [7:0] rom_vec_s;
  logic       rom_exp_s;

  or8way_self_test_vector_rom u_rom (
    .index_i    (idx_q),
    .vector_o   (rom_vec_s),
    .expected_o (rom_exp_s)
  );

  // Next-state logic of the sequencer and its result registers.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pass_res_d = pass_res_q;
    fail_res_d = fail_res_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_APPLY;
          idx_d      = 4'd0;
          pass_res_d = 1'b0;
          fail_res_d = FAIL_NONE;
        end else begin
          state_d = state_q;
        end
      end
      ST_APPLY: begin
        cnt_d = SETTLE_LOAD;
        if (SETTLE_LOAD == 4'd0) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_CHECK: begin
        if (dut_out != rom_exp_s) begin
          state_d    = ST_DONE;
          pass_res_d = 1'b0;
          fail_res_d = idx_q;
        end else if (idx_q >= LAST_INDEX) begin
          state_d    = ST_DONE;
          pass_res_d = 1'b1;
          fail_res_d = FAIL_NONE;
        end else begin
          state_d = ST_APPLY;
          idx_d   = idx_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // Output decode from the current state; registered below so every status
  // port changes one edge after the state it reflects.
  always_comb begin
    busy_d       = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                   (state_q == ST_CHECK);
    dut_in_d     = busy_d ? rom_vec_s : 8'h00;
    done_d       = (state_q == ST_DONE);
    pass_d       = done_d & pass_res_q;
    fail_index_d = done_d ? fail_res_q : FAIL_NONE;
  end

  // State, result and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 4'd0;
      cnt_q        <= 4'd0;
      pass_res_q   <= 1'b0;
      fail_res_q   <= FAIL_NONE;
      dut_in_q     <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_index_q <= FAIL_NONE;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pass_res_q   <= pass_res_d;
      fail_res_q   <= fail_res_d;
      dut_in_q     <= dut_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_index_q <= fail_index_d;
    end
  end

  assign dut_in     = dut_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_index = fail_index_q;
  assign led0       = busy_q;
  assign led1       = done_q & pass_q;
  assign led2       = done_q & ~pass_q;
  assign led3       = dut_out;

endmodule

// File: tb/tb_or8way_self_test.sv
// Scoreboard bench for or8way_self_test: two instances (settle 2 and 0)
// each driving a behavioural Or8Way model with selectable faults.
module tb_or8way_self_test;

  localparam int MODE_GOOD  = 0;
  localparam int MODE_IN7SA0 = 1;
  localparam int MODE_OUTSA1 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  int   mode_a = MODE_GOOD, mode_b = MODE_GOOD;

  logic [7:0] din_a, din_b;
  logic       dout_a, dout_b;
  logic       busy_a, done_a, pass_a, l0_a, l1_a, l2_a, l3_a;
  logic       busy_b, done_b, pass_b, l0_b, l1_b, l2_b, l3_b;
  logic [3:0] fi_a, fi_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic model_out(input int mode, input logic [7:0] v);
    logic r;
    if (mode == MODE_IN7SA0) r = |(v & 8'h7F);
    else if (mode == MODE_OUTSA1) r = 1'b1;
    else r = |v;
    return r;
  endfunction

  function automatic logic [7:0] golden_vec(input int k);
    logic [7:0] one;
    one = 8'h01;
    if (k < 8) return one << k;
    else if (k == 8) return 8'hFF;
    else return 8'h00;
  endfunction

  assign dout_a = model_out(mode_a, din_a);
  assign dout_b = model_out(mode_b, din_b);

  or8way_self_test #(.SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_in(din_a), .dut_out(dout_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_index(fi_a),
    .led0(l0_a), .led1(l1_a), .led2(l2_a), .led3(l3_a));

  or8way_self_test #(.SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_in(din_b), .dut_out(dout_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_index(fi_b),
    .led0(l0_b), .led1(l1_b), .led2(l2_b), .led3(l3_b));

  function automatic logic [31:0] pk(input logic busy, input logic done,
      input logic pass, input logic [3:0] fi, input logic [7:0] din,
      input logic l3);
    return {13'd0, busy, done, pass, fi, din, busy, done & pass, done & ~pass, l3};
  endfunction

  function automatic logic [31:0] observed(input int which);
    if (which == 0)
      return {13'd0, busy_a, done_a, pass_a, fi_a, din_a, l0_a, l1_a, l2_a, l3_a};
    else
      return {13'd0, busy_b, done_b, pass_b, fi_b, din_b, l0_b, l1_b, l2_b, l3_b};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); @(negedge clk);
      check_eq(tag, observed(0), pk(1'b0, 1'b0, 1'b0, 4'hF, 8'h00, model_out(mode_a, 8'h00)));
      check_eq(tag, observed(1), pk(1'b0, 1'b0, 1'b0, 4'hF, 8'h00, model_out(mode_b, 8'h00)));
    end
  endtask

  // Push the expected per-cycle image of a run, start it, then pop and
  // compare once per cycle. Optionally spam start while the run is busy.
  task automatic do_run(input string tag, input int which, input int mode,
                        input int s, input bit spam);
    int per, nvec, fidx, nbusy, ntot, vi;
    logic [7:0] v;
    logic [31:0] e;
    per  = 2 + s;
    fidx = 15;
    for (int k = 0; k < 10; k++) begin
      if (fidx == 15 && model_out(mode, golden_vec(k)) != |golden_vec(k)) fidx = k;
    end
    nvec  = (fidx == 15) ? 10 : fidx + 1;
    nbusy = nvec * per;
    ntot  = nbusy + 3;
    exp_q.delete();
    for (int c = 1; c <= ntot; c++) begin
      if (c <= nbusy) begin
        vi = (c - 1) / per;
        v  = golden_vec(vi);
        exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 4'hF, v, model_out(mode, v)));
      end else begin
        exp_q.push_back(pk(1'b0, 1'b1, (fidx == 15), 4'(fidx), 8'h00,
                           model_out(mode, 8'h00)));
      end
    end
    if (which == 0) mode_a = mode; else mode_b = mode;
    @(posedge clk); #1;
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    for (int c = 1; c <= ntot; c++) begin
      @(posedge clk); @(negedge clk);
      if (exp_q.size() == 0) begin
        check_eq({tag, "_qempty"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq(tag, observed(which), e);
      end
      if (spam && (c % 2 == 1) && (c < nbusy)) begin
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
    end
    start_a = 1'b0; start_b = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset_idle", 20);

    do_run("pass_s2", 0, MODE_GOOD, 2, 1'b0);
    do_run("rerun_from_done_spam", 0, MODE_GOOD, 2, 1'b1);
    do_run("fail_in7", 0, MODE_IN7SA0, 2, 1'b0);
    do_run("fail_out1", 0, MODE_OUTSA1, 2, 1'b0);
    do_run("fail_out1_s0", 1, MODE_OUTSA1, 0, 1'b0);
    do_run("pass_s0", 1, MODE_GOOD, 0, 1'b0);

    // Mid-run reset with a simultaneous start.
    mode_a = MODE_GOOD;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); @(negedge clk);
    end
    check_eq("midrun_busy", observed(0), pk(1'b1, 1'b0, 1'b0, 4'hF, 8'h08, 1'b1));
    rst = 1'b1; start_a = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("rst_midrun", observed(0), pk(1'b0, 1'b0, 1'b0, 4'hF, 8'h00, 1'b0));
    rst = 1'b0; start_a = 1'b0;
    check_idle("after_rst", 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
